// File: rtl/seq_clk_step_gen.sv
// Sequence-clock generator: divides REF_CLK_TICK by DIV and steps an index modulo CYCLE.
// Start is aligned to SYNC; CYCLE/DIV/LOOP are shadow-buffered and reloaded at INIT or wrap.
module seq_clk_step_gen #(
   parameter int CYCLE_W = 16,
   parameter int DIV_W   = 16
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               SEQ_CLK_INIT,
   input  logic               SYNC,
   input  logic               REF_CLK_TICK,
   input  logic [CYCLE_W-1:0] CYCLE_IN,
   input  logic [DIV_W-1:0]   DIV_IN,
   input  logic               LOOP_MODE,
   input  logic               UPDATE,
   output logic [CYCLE_W-1:0] SEQ_IDX,
   output logic               SEQ_STEP,
   output logic               SEQ_WRAP,
   output logic               RUNNING,
   output logic               DONE
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CYCLE_W-1:0] CYCLE_ONE = CYCLE_W'(1);
   localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);

   state_t             state_q, state_d;
   logic [CYCLE_W-1:0] idx_q, idx_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic               step_q, step_d;
   logic               wrap_q, wrap_d;
   logic               running_q, running_d;
   logic               done_q, done_d;

   logic [CYCLE_W-1:0] cycle_sh_q, cycle_sh_d;
   logic [DIV_W-1:0]   div_sh_q, div_sh_d;
   logic               loop_sh_q, loop_sh_d;
   logic [CYCLE_W-1:0] cycle_act_q, cycle_act_d;
   logic [DIV_W-1:0]   div_act_q, div_act_d;
   logic               loop_act_q, loop_act_d;

   logic [CYCLE_W-1:0] cycle_in_m;
   logic [DIV_W-1:0]   div_in_m;
   logic               div_hit;
   logic               idx_last;

   assign cycle_in_m = (CYCLE_IN == '0) ? CYCLE_ONE : CYCLE_IN;
   assign div_in_m   = (DIV_IN == '0) ? DIV_ONE : DIV_IN;

   // Active values only change while idx/div_cnt are zero, so these compares never overshoot.
   assign div_hit  = (div_cnt_q == div_act_q - DIV_ONE);
   assign idx_last = (idx_q == cycle_act_q - CYCLE_ONE);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      div_cnt_d   = div_cnt_q;
      step_d      = 1'b0;
      wrap_d      = 1'b0;
      running_d   = running_q;
      done_d      = done_q;
      cycle_sh_d  = cycle_sh_q;
      div_sh_d    = div_sh_q;
      loop_sh_d   = loop_sh_q;
      cycle_act_d = cycle_act_q;
      div_act_d   = div_act_q;
      loop_act_d  = loop_act_q;

      if (UPDATE) begin
         cycle_sh_d = cycle_in_m;
         div_sh_d   = div_in_m;
         loop_sh_d  = LOOP_MODE;
      end

      if (SEQ_CLK_INIT) begin
         state_d     = ST_ARMED;
         idx_d       = '0;
         div_cnt_d   = '0;
         running_d   = 1'b0;
         done_d      = 1'b0;
         cycle_act_d = cycle_sh_d;
         div_act_d   = div_sh_d;
         loop_act_d  = loop_sh_d;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_ARMED: begin
               if (SYNC) begin
                  state_d   = ST_RUN;
                  idx_d     = '0;
                  div_cnt_d = '0;
                  running_d = 1'b1;
               end
            end
            ST_RUN: begin
               if (REF_CLK_TICK) begin
                  if (!div_hit) begin
                     div_cnt_d = div_cnt_q + DIV_ONE;
                  end else begin
                     div_cnt_d = '0;
                     if (!idx_last) begin
                        idx_d  = idx_q + CYCLE_ONE;
                        step_d = 1'b1;
                     end else if (loop_act_q) begin
                        idx_d       = '0;
                        step_d      = 1'b1;
                        wrap_d      = 1'b1;
                        cycle_act_d = cycle_sh_d;
                        div_act_d   = div_sh_d;
                        loop_act_d  = loop_sh_d;
                     end else begin
                        state_d   = ST_DONE;
                        running_d = 1'b0;
                        done_d    = 1'b1;
                     end
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         div_cnt_q   <= '0;
         step_q      <= 1'b0;
         wrap_q      <= 1'b0;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
         cycle_sh_q  <= CYCLE_ONE;
         div_sh_q    <= DIV_ONE;
         loop_sh_q   <= 1'b1;
         cycle_act_q <= CYCLE_ONE;
         div_act_q   <= DIV_ONE;
         loop_act_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         div_cnt_q   <= div_cnt_d;
         step_q      <= step_d;
         wrap_q      <= wrap_d;
         running_q   <= running_d;
         done_q      <= done_d;
         cycle_sh_q  <= cycle_sh_d;
         div_sh_q    <= div_sh_d;
         loop_sh_q   <= loop_sh_d;
         cycle_act_q <= cycle_act_d;
         div_act_q   <= div_act_d;
         loop_act_q  <= loop_act_d;
      end
   end

   assign SEQ_IDX  = idx_q;
   assign SEQ_STEP = step_q;
   assign SEQ_WRAP = wrap_q;
   assign RUNNING  = running_q;
   assign DONE     = done_q;

endmodule

// File: tb/tb_seq_clk_step_gen.sv
// Self-checking bench for seq_clk_step_gen: vector table, directed corner sequences,
// and randomized traffic against a behavioural model.
module tb_seq_clk_step_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        init, sync, tick, update, loop_mode;
   logic [15:0] cycle_in, div_in;
   logic [15:0] seq_idx;
   logic        seq_step, seq_wrap, running, done;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   seq_clk_step_gen #(.CYCLE_W(16), .DIV_W(16)) dut (
      .CLK          (clk),
      .RST_N        (rst_n),
      .SEQ_CLK_INIT (init),
      .SYNC         (sync),
      .REF_CLK_TICK (tick),
      .CYCLE_IN     (cycle_in),
      .DIV_IN       (div_in),
      .LOOP_MODE    (loop_mode),
      .UPDATE       (update),
      .SEQ_IDX      (seq_idx),
      .SEQ_STEP     (seq_step),
      .SEQ_WRAP     (seq_wrap),
      .RUNNING      (running),
      .DONE         (done)
   );

   // Behavioural model: plain integers, counts ticks up to DIV and steps while idx+1 < CYCLE.
   localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;
   int m_state, m_idx, m_cnt, a_cyc, a_div, s_cyc, s_div;
   bit a_loop, s_loop, m_step, m_wrap;

   task automatic model_reset();
      m_state = M_IDLE; m_idx = 0; m_cnt = 0; m_step = 0; m_wrap = 0;
      a_cyc = 1; a_div = 1; a_loop = 1; s_cyc = 1; s_div = 1; s_loop = 1;
   endtask

   task automatic model_step(input bit i_init, i_sync, i_tick, i_upd,
                             input int cin, din, input bit lin);
      m_step = 0;
      m_wrap = 0;
      if (i_upd) begin
         s_cyc  = (cin == 0) ? 1 : cin;
         s_div  = (din == 0) ? 1 : din;
         s_loop = lin;
      end
      if (i_init) begin
         a_cyc = s_cyc; a_div = s_div; a_loop = s_loop;
         m_state = M_ARMED; m_idx = 0; m_cnt = 0;
      end else if (m_state == M_ARMED && i_sync) begin
         m_state = M_RUN; m_idx = 0; m_cnt = 0;
      end else if (m_state == M_RUN && i_tick) begin
         m_cnt++;
         if (m_cnt == a_div) begin
            m_cnt = 0;
            if (m_idx + 1 < a_cyc) begin
               m_idx++;
               m_step = 1;
            end else if (a_loop) begin
               m_idx = 0; m_step = 1; m_wrap = 1;
               a_cyc = s_cyc; a_div = s_div; a_loop = s_loop;
            end else begin
               m_state = M_DONE;
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic clk_cycle(input bit i_init, i_sync, i_tick, i_upd,
                            input int cin, din, input bit lin);
      init = i_init; sync = i_sync; tick = i_tick; update = i_upd;
      cycle_in = 16'(cin); div_in = 16'(din); loop_mode = lin;
      model_step(i_init, i_sync, i_tick, i_upd, cin, din, lin);
      @(posedge clk);
      #1;
      init = 0; sync = 0; tick = 0; update = 0;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_idx"},  seq_idx,  m_idx);
      chk({tag, "_step"}, seq_step, m_step);
      chk({tag, "_wrap"}, seq_wrap, m_wrap);
      chk({tag, "_run"},  running,  (m_state == M_RUN));
      chk({tag, "_done"}, done,     (m_state == M_DONE));
   endtask

   typedef struct {
      bit init, sync, tick, upd;
      int cin, din;
      bit lin;
      int e_idx;
      bit e_step, e_wrap, e_run, e_done;
   } vec_t;

   vec_t tbl[17];
   int   exp3[6];

   initial begin
      // one-shot CYCLE=3 DIV=1
      tbl[0]  = '{1,0,0,1, 3,1,0, 0,0,0,0,0};
      tbl[1]  = '{0,1,0,0, 0,0,0, 0,0,0,1,0};
      tbl[2]  = '{0,0,1,0, 0,0,0, 1,1,0,1,0};
      tbl[3]  = '{0,0,1,0, 0,0,0, 2,1,0,1,0};
      tbl[4]  = '{0,0,1,0, 0,0,0, 2,0,0,0,1};
      tbl[5]  = '{0,0,1,0, 0,0,0, 2,0,0,0,1};
      tbl[6]  = '{0,0,1,0, 0,0,0, 2,0,0,0,1};
      // zero inputs behave as 1/1; SYNC+TICK in ARMED ignores the tick
      tbl[7]  = '{1,0,0,1, 0,0,1, 0,0,0,0,0};
      tbl[8]  = '{0,1,1,0, 0,0,0, 0,0,0,1,0};
      tbl[9]  = '{0,0,1,0, 0,0,0, 0,1,1,1,0};
      tbl[10] = '{0,0,1,0, 0,0,0, 0,1,1,1,0};
      tbl[11] = '{0,0,0,0, 0,0,0, 0,0,0,1,0};
      tbl[12] = '{0,0,1,0, 0,0,0, 0,1,1,1,0};
      // INIT beats SYNC in RUN; ARMED ignores ticks; SYNC in RUN ignored
      tbl[13] = '{1,1,0,0, 0,0,0, 0,0,0,0,0};
      tbl[14] = '{0,0,1,0, 0,0,0, 0,0,0,0,0};
      tbl[15] = '{0,1,0,0, 0,0,0, 0,0,0,1,0};
      tbl[16] = '{0,1,1,0, 0,0,0, 0,1,1,1,0};
      exp3 = '{2, 3, 0, 1, 0, 1};

      rst_n = 0; init = 0; sync = 0; tick = 0; update = 0;
      cycle_in = 0; div_in = 0; loop_mode = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_idx", seq_idx, 0);
      chk("rst_step", seq_step, 0);
      chk("rst_wrap", seq_wrap, 0);
      chk("rst_run", running, 0);
      chk("rst_done", done, 0);
      rst_n = 1;

      for (int v = 0; v < 17; v++) begin
         clk_cycle(tbl[v].init, tbl[v].sync, tbl[v].tick, tbl[v].upd,
                   tbl[v].cin, tbl[v].din, tbl[v].lin);
         $display("vec %0d: idx=%0d step=%0b wrap=%0b run=%0b done=%0b",
                  v, seq_idx, seq_step, seq_wrap, running, done);
         chk($sformatf("vec%0d_idx", v),  seq_idx,  tbl[v].e_idx);
         chk($sformatf("vec%0d_step", v), seq_step, tbl[v].e_step);
         chk($sformatf("vec%0d_wrap", v), seq_wrap, tbl[v].e_wrap);
         chk($sformatf("vec%0d_run", v),  running,  tbl[v].e_run);
         chk($sformatf("vec%0d_done", v), done,     tbl[v].e_done);
      end

      // CYCLE=4 DIV=3 loop: index advances every third tick, wraps on tick 12
      clk_cycle(1, 0, 0, 1, 4, 3, 1);
      clk_cycle(0, 1, 0, 0, 0, 0, 0);
      for (int t = 1; t <= 12; t++) begin
         clk_cycle(0, 0, 1, 0, 0, 0, 0);
         chk($sformatf("div3_t%0d_idx", t),  seq_idx,  (t / 3) % 4);
         chk($sformatf("div3_t%0d_step", t), seq_step, (t % 3 == 0));
         chk($sformatf("div3_t%0d_wrap", t), seq_wrap, (t == 12));
      end

      // shadow update mid-run takes effect only after the current length completes
      clk_cycle(1, 0, 0, 1, 4, 1, 1);
      clk_cycle(0, 1, 0, 0, 0, 0, 0);
      clk_cycle(0, 0, 1, 0, 0, 0, 0);
      chk("shadow_pre_idx", seq_idx, 1);
      clk_cycle(0, 0, 0, 1, 2, 1, 1);
      chk("shadow_upd_idx", seq_idx, 1);
      for (int k = 0; k < 6; k++) begin
         clk_cycle(0, 0, 1, 0, 0, 0, 0);
         chk($sformatf("shadow_k%0d_idx", k),  seq_idx,  exp3[k]);
         chk($sformatf("shadow_k%0d_wrap", k), seq_wrap, (exp3[k] == 0));
      end

      // asynchronous reset mid-run
      clk_cycle(1, 0, 0, 1, 4, 1, 1);
      clk_cycle(0, 1, 0, 0, 0, 0, 0);
      clk_cycle(0, 0, 1, 0, 0, 0, 0);
      clk_cycle(0, 0, 1, 0, 0, 0, 0);
      chk("arst_pre_idx", seq_idx, 2);
      #2;
      rst_n = 0;
      model_reset();
      #1;
      chk("arst_idx", seq_idx, 0);
      chk("arst_run", running, 0);
      chk("arst_step", seq_step, 0);
      @(posedge clk);
      #1;
      rst_n = 1;
      for (int k = 0; k < 3; k++) begin
         clk_cycle(0, 1, 1, 0, 0, 0, 0);
         chk($sformatf("arst_idle%0d_run", k), running, 0);
         chk($sformatf("arst_idle%0d_step", k), seq_step, 0);
      end
      clk_cycle(1, 0, 0, 0, 0, 0, 0);
      chk("arst_armed_run", running, 0);
      clk_cycle(0, 1, 0, 0, 0, 0, 0);
      chk("arst_sync_run", running, 1);
      clk_cycle(0, 0, 1, 0, 0, 0, 0);
      chk("arst_def_step", seq_step, 1);
      chk("arst_def_wrap", seq_wrap, 1);
      chk("arst_def_idx", seq_idx, 0);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 499) == 0) begin
            #2;
            rst_n = 0;
            model_reset();
            #1;
            rst_n = 1;
         end
         clk_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0);
         chk_model("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
